// File: rtl/instr_fetch_unit.sv
// Program sequencer: fetches ROM words, feeds Din, and issues
// one instruction at a time to the control FSM via run/Done.
module instr_fetch_unit #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 9,
  parameter int PROG_LEN = 32,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              IRin,
  input  logic              Done,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] Din,
  output logic              run,
  output logic              busy,
  output logic              prog_done,
  output logic              timeout_err,
  output logic [7:0]        instr_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_ROMWAIT   = 4'd2;
  localparam logic [3:0] S_DECODE    = 4'd3;
  localparam logic [3:0] S_WAIT_IR   = 4'd4;
  localparam logic [3:0] S_IMM_FETCH = 4'd5;
  localparam logic [3:0] S_IMM_WAIT  = 4'd6;
  localparam logic [3:0] S_EXEC      = 4'd7;
  localparam logic [3:0] S_END       = 4'd8;

  logic [3:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [WD_W-1:0]   wd;
  logic [2:0]        op;
  logic              is_halt;
  logic              is_mvi;
  logic              pc_last;
  logic              wd_hit;

  assign op      = Din[DATA_W-1 -: 3];
  assign is_halt = (op == 3'b111);
  assign is_mvi  = (op == 3'b001);
  assign pc_last = (pc == ADDR_W'(PROG_LEN - 1));
  // >= so an IRin accepted on the last allowed cycle still trips later
  assign wd_hit  = (wd >= WD_W'(TIMEOUT - 1));

  assign run  = (state == S_DECODE) && !is_halt;
  assign busy = (state != S_IDLE) && (state != S_END);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      ADDRESS     <= '0;
      Din         <= '0;
      prog_done   <= 1'b0;
      timeout_err <= 1'b0;
      instr_count <= '0;
      pc          <= '0;
      wd          <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_END: begin
          if (start) begin
            state       <= S_FETCH;
            pc          <= '0;
            prog_done   <= 1'b0;
            timeout_err <= 1'b0;
            instr_count <= '0;
          end
        end
        S_FETCH: begin
          ADDRESS <= pc;
          state   <= S_ROMWAIT;
        end
        S_ROMWAIT: begin
          Din   <= rom_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (is_halt) begin
            prog_done <= 1'b1;
            state     <= S_END;
          end else begin
            wd    <= '0;
            state <= S_WAIT_IR;
          end
        end
        S_WAIT_IR: begin
          if (IRin) begin
            wd <= wd + 1'b1;
            if (is_mvi && pc_last) begin
              timeout_err <= 1'b1;
              prog_done   <= 1'b1;
              state       <= S_END;
            end else if (is_mvi) begin
              pc    <= pc + 1'b1;
              state <= S_IMM_FETCH;
            end else begin
              state <= S_EXEC;
            end
          end else if (wd_hit) begin
            timeout_err <= 1'b1;
            prog_done   <= 1'b1;
            state       <= S_END;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_IMM_FETCH: begin
          if (wd_hit) begin
            timeout_err <= 1'b1;
            prog_done   <= 1'b1;
            state       <= S_END;
          end else begin
            ADDRESS <= pc;
            wd      <= wd + 1'b1;
            state   <= S_IMM_WAIT;
          end
        end
        S_IMM_WAIT: begin
          if (wd_hit) begin
            timeout_err <= 1'b1;
            prog_done   <= 1'b1;
            state       <= S_END;
          end else begin
            Din   <= rom_data;
            wd    <= wd + 1'b1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (Done) begin
            if (instr_count != 8'hFF)
              instr_count <= instr_count + 8'd1;
            if (pc_last) begin
              prog_done <= 1'b1;
              state     <= S_END;
            end else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end else if (wd_hit) begin
            timeout_err <= 1'b1;
            prog_done   <= 1'b1;
            state       <= S_END;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
